// File: rtl/io_pkg.sv
// Shared types and constants for the I/O unit output statement machine.
// State indices, state encodings, character codes and default digit counts.
package io_pkg;

    localparam int OCT_DIGITS_DEF = 10;
    localparam int DEC_DIGITS_DEF = 8;

    localparam int S_IDLE     = 0;
    localparam int S_SIGN     = 1;
    localparam int S_SIGN_REL = 2;
    localparam int S_SHIFT    = 3;
    localparam int S_WAIT_AC  = 4;
    localparam int S_DIG      = 5;
    localparam int S_DIG_REL  = 6;
    localparam int S_END      = 7;
    localparam int S_END_REL  = 8;
    localparam int S_DONE     = 9;
    localparam int S_NUM      = 10;

    typedef enum logic [S_NUM-1:0] {
        ST_IDLE     = 10'b1 << S_IDLE,
        ST_SIGN     = 10'b1 << S_SIGN,
        ST_SIGN_REL = 10'b1 << S_SIGN_REL,
        ST_SHIFT    = 10'b1 << S_SHIFT,
        ST_WAIT_AC  = 10'b1 << S_WAIT_AC,
        ST_DIG      = 10'b1 << S_DIG,
        ST_DIG_REL  = 10'b1 << S_DIG_REL,
        ST_END      = 10'b1 << S_END,
        ST_END_REL  = 10'b1 << S_END_REL,
        ST_DONE     = 10'b1 << S_DONE
    } out_state_e;

    localparam logic [4:0] CH_PLUS  = 5'b00010;
    localparam logic [4:0] CH_MINUS = 5'b00011;
    localparam logic [4:0] CH_END   = 5'b00111;

    // Numeric characters carry bit 4; octal drops the top digit bit.
    function automatic logic [4:0] digit_code(
        input logic       dec,
        input logic [3:0] d
    );
        return dec ? {1'b1, d} : {2'b10, d[2:0]};
    endfunction

endpackage

// File: rtl/io_out_handshake.sv
// Four-phase character sender shared by the sign, digit and end phases.
// Valid never rises while ack is high; a request made then is held armed.
module io_out_handshake
    import io_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic i_send,
    input  logic i_ack,
    output logic o_valid,
    output logic o_taken,
    output logic o_done
);

    logic r_arm;
    logic r_valid;
    logic r_rel;
    logic w_req;

    assign w_req = i_send | r_arm;

    // Request / release sequencing of the link.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_arm   <= 1'b0;
            r_valid <= 1'b0;
            r_rel   <= 1'b0;
        end else if (r_valid) begin
            if (i_ack) begin
                r_valid <= 1'b0;
                r_rel   <= 1'b1;
            end
        end else if (r_rel && i_ack) begin
            if (i_send) begin
                r_arm <= 1'b1;
            end
        end else begin
            r_rel <= 1'b0;
            if (w_req) begin
                r_valid <= ~i_ack;
                r_arm   <= i_ack;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_taken = r_valid & i_ack;
    assign o_done  = r_rel & ~i_ack;

endmodule

// File: rtl/io_output_unit.sv
// Output statement machine: sign, N digits shifted out of AC, optional end.
// IO_OUT_END_CODE_EN enables the trailing end character.
module io_output_unit
    import io_pkg::*;
#(
    parameter int OCT_DIGITS = OCT_DIGITS_DEF,
    parameter int DEC_DIGITS = DEC_DIGITS_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       order_output_from_op,
    input  logic       output_oct_from_pnl,
    input  logic       output_dec_from_pnl,
    input  logic       stop_after_output_from_pnl,
    input  logic       ac_answer_from_ac,
    input  logic       output_sign_from_ac,
    input  logic [3:0] output_data_from_au,
    input  logic       output_ack_from_dev,
    output logic       output_active_to_io,
    output logic       shift_3_bit_to_ac,
    output logic       shift_4_bit_to_ac,
    output logic       order_io_to_ac,
    output logic       start_pulse_to_pu,
    output logic       output_valid_to_dev,
    output logic [4:0] output_data_to_dev
);

    if ((OCT_DIGITS < 1) || (OCT_DIGITS > 15) ||
        (DEC_DIGITS < 1) || (DEC_DIGITS > 15)) begin : g_bad_digits
        $error("io_output_unit: digit counts must be in 1..15");
    end

    localparam logic [3:0] N_OCT = 4'(OCT_DIGITS);
    localparam logic [3:0] N_DEC = 4'(DEC_DIGITS);

    out_state_e r_state;
    out_state_e w_next;
    logic       r_dec;
    logic [3:0] r_cnt;
    logic [4:0] r_data;
    logic       r_start;

    logic       w_send;
    logic       w_begin;
    logic       w_load_sign;
    logic       w_load_dig;
    logic       w_load_end;
    logic       w_load_start;
    logic       w_cnt_inc;
    logic       w_last;
    logic [3:0] w_n;
    logic       w_valid;
    logic       w_taken;
    logic       w_done;

    assign w_n    = r_dec ? N_DEC : N_OCT;
    assign w_last = (r_cnt == (w_n - 4'd1));

    io_out_handshake u_hs (
        .clk     (clk),
        .resetn  (resetn),
        .i_send  (w_send),
        .i_ack   (output_ack_from_dev),
        .o_valid (w_valid),
        .o_taken (w_taken),
        .o_done  (w_done)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-phase load strobes.
    always_comb begin
        w_next       = r_state;
        w_send       = 1'b0;
        w_begin      = 1'b0;
        w_load_sign  = 1'b0;
        w_load_dig   = 1'b0;
        w_load_end   = 1'b0;
        w_load_start = 1'b0;
        w_cnt_inc    = 1'b0;
        unique case (1'b1)
            r_state[S_IDLE]: begin
                if (order_output_from_op) begin
                    w_next      = ST_SIGN;
                    w_send      = 1'b1;
                    w_begin     = 1'b1;
                    w_load_sign = 1'b1;
                end
            end
            r_state[S_SIGN]: begin
                if (w_taken) begin
                    w_next = ST_SIGN_REL;
                end
            end
            r_state[S_SIGN_REL]: begin
                if (w_done) begin
                    w_next = ST_SHIFT;
                end
            end
            r_state[S_SHIFT]: begin
                w_next = ST_WAIT_AC;
            end
            r_state[S_WAIT_AC]: begin
                if (ac_answer_from_ac) begin
                    w_next     = ST_DIG;
                    w_send     = 1'b1;
                    w_load_dig = 1'b1;
                end
            end
            r_state[S_DIG]: begin
                if (w_taken) begin
                    w_next = ST_DIG_REL;
                end
            end
            r_state[S_DIG_REL]: begin
                if (w_done) begin
                    w_cnt_inc = 1'b1;
                    if (w_last) begin
`ifdef IO_OUT_END_CODE_EN
                        w_next     = ST_END;
                        w_send     = 1'b1;
                        w_load_end = 1'b1;
`else
                        w_next       = ST_DONE;
                        w_load_start = 1'b1;
`endif
                    end else begin
                        w_next = ST_SHIFT;
                    end
                end
            end
`ifdef IO_OUT_END_CODE_EN
            r_state[S_END]: begin
                if (w_taken) begin
                    w_next = ST_END_REL;
                end
            end
            r_state[S_END_REL]: begin
                if (w_done) begin
                    w_next       = ST_DONE;
                    w_load_start = 1'b1;
                end
            end
`endif
            r_state[S_DONE]: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Mode latch, digit counter, character register and restart pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dec   <= 1'b0;
            r_cnt   <= 4'd0;
            r_data  <= 5'd0;
            r_start <= 1'b0;
        end else begin
            r_start <= w_load_start & ~stop_after_output_from_pnl;
            if (w_begin) begin
                r_dec <= output_dec_from_pnl;
                r_cnt <= 4'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_load_sign) begin
                r_data <= output_sign_from_ac ? CH_MINUS : CH_PLUS;
            end else if (w_load_dig) begin
                r_data <= digit_code(r_dec, output_data_from_au);
            end else if (w_load_end) begin
                r_data <= CH_END;
            end
        end
    end

    assign output_active_to_io = ~r_state[S_IDLE];
    assign shift_3_bit_to_ac   = ~r_state[S_IDLE] & ~r_dec;
    assign shift_4_bit_to_ac   = ~r_state[S_IDLE] & r_dec;
    assign order_io_to_ac      = r_state[S_SHIFT];
    assign start_pulse_to_pu   = r_start;
    assign output_valid_to_dev = w_valid;
    assign output_data_to_dev  = r_data;

    logic w_unused;
    assign w_unused = output_oct_from_pnl;

endmodule

// File: tb/tb_io_output_unit.sv
// Testbench for io_output_unit: vector table of whole words plus
// hand sequences for ack-held, mid-word order and async reset.
module tb_io_output_unit;
    import io_pkg::*;

`ifdef IO_OUT_END_CODE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       order = 1'b0;
    logic       p_oct = 1'b0;
    logic       p_dec = 1'b0;
    logic       p_stop = 1'b0;
    logic       ac_answer = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] au = 4'd0;
    logic       ack = 1'b0;
    logic       active, sh3, sh4, order_io, start, valid;
    logic [4:0] data;

    always #5 clk = ~clk;

    io_output_unit dut (
        .clk                        (clk),
        .resetn                     (resetn),
        .order_output_from_op       (order),
        .output_oct_from_pnl        (p_oct),
        .output_dec_from_pnl        (p_dec),
        .stop_after_output_from_pnl (p_stop),
        .ac_answer_from_ac          (ac_answer),
        .output_sign_from_ac        (sign),
        .output_data_from_au        (au),
        .output_ack_from_dev        (ack),
        .output_active_to_io        (active),
        .shift_3_bit_to_ac          (sh3),
        .shift_4_bit_to_ac          (sh4),
        .order_io_to_ac             (order_io),
        .start_pulse_to_pu          (start),
        .output_valid_to_dev        (valid),
        .output_data_to_dev         (data)
    );

    typedef struct {
        bit                 dec;
        bit                 oct;
        bit                 sgn;
        bit                 stop;
        int                 adly;
        int                 acdly;
        logic [9:0][3:0]    dig;
        int                 n;
        logic [4:0]         sch;
        logic [9:0][4:0]    dch;
        int                 starts;
    } vec_t;

    vec_t tbl[5];

    int checks = 0;
    int failures = 0;

    // Device / AC model state.
    int              ack_dly = 0;
    bit              dev_hold = 0;
    logic [4:0]      rx_q[$];
    int              vio = 0;
    int              stab_err = 0;
    logic [4:0]      first_data = 5'd0;
    int              dcnt = 0;
    logic            prev_valid = 1'b0;
    logic [9:0][3:0] cur_dig;
    int              ac_idx = 0;
    int              ac_dly = 0;
    int              ac_cnt = 0;
    bit              ac_pend = 0;
    int              n_orders = 0;
    int              n_starts = 0;
    int              s_bad = 0;
    bit              exp_dec = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Four-phase receiver with programmable ack delay.
    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            ack = 1'b0;
            dcnt = 0;
            prev_valid = 1'b0;
        end else begin
            if (valid && !prev_valid && ack) vio++;
            if (valid && !prev_valid) first_data = data;
            if (valid && data !== first_data) stab_err++;
            prev_valid = valid;
            if (dev_hold) begin
                ack = 1'b1;
            end else if (!ack) begin
                if (valid) begin
                    if (dcnt >= ack_dly) begin
                        rx_q.push_back(data);
                        ack = 1'b1;
                        dcnt = 0;
                    end else begin
                        dcnt++;
                    end
                end
            end else if (!valid) begin
                ack = 1'b0;
            end
        end
    end

    // AC/AU model: answers each shift request after ac_dly cycles.
    initial forever begin
        @(negedge clk);
        ac_answer = 1'b0;
        if (!resetn) begin
            ac_pend = 0;
        end else begin
            if (order_io) begin
                n_orders++;
                ac_pend = 1;
                ac_cnt = 0;
            end else if (ac_pend) begin
                if (ac_cnt >= ac_dly) begin
                    ac_answer = 1'b1;
                    if (ac_idx < 10) au = cur_dig[ac_idx];
                    ac_idx++;
                    ac_pend = 0;
                end else begin
                    ac_cnt++;
                end
            end
            if (start) n_starts++;
            if (active && (sh3 !== !exp_dec || sh4 !== exp_dec)) s_bad++;
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        n_orders = 0;
        n_starts = 0;
        s_bad = 0;
        vio = 0;
        stab_err = 0;
        ac_idx = 0;
    endtask

    task automatic start_word(input bit dec, input bit oct,
                              input bit sg, input bit stp);
        step();
        p_dec = dec;
        p_oct = oct;
        sign = sg;
        p_stop = stp;
        exp_dec = dec;
        order = 1'b1;
        step();
        order = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (active && c < 3000) begin
            step();
            c++;
        end
        chk($sformatf("%s_finish", tag), (c < 3000), 1);
        step();
    endtask

    task automatic check_word(input string tag, input int n,
                              input logic [4:0] sch,
                              input logic [9:0][4:0] dch,
                              input int starts);
        int total;
        logic [31:0] act;
        logic [31:0] exp;
        total = n + 1 + EXTRA;
        chk($sformatf("%s_len", tag), rx_q.size(), total);
        for (int k = 0; k < total; k++) begin
            act = (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hdead;
            if (k == 0) exp = 32'(sch);
            else if (k <= n) exp = 32'(dch[k-1]);
            else exp = 32'(CH_END);
            chk($sformatf("%s_ch%0d", tag, k), act, exp);
        end
        chk($sformatf("%s_orders", tag), n_orders, n);
        chk($sformatf("%s_starts", tag), n_starts, starts);
        chk($sformatf("%s_shiftmode", tag), s_bad, 0);
        chk($sformatf("%s_valid_vs_ack", tag), vio, 0);
        chk($sformatf("%s_stable", tag), stab_err, 0);
    endtask

    initial begin
        tbl[0] = '{dec:0, oct:1, sgn:0, stop:0, adly:2, acdly:1,
            dig:{4'd2,4'd1,4'd0,4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1},
            n:10, sch:5'h02,
            dch:{5'h12,5'h11,5'h10,5'h17,5'h16,
                 5'h15,5'h14,5'h13,5'h12,5'h11},
            starts:1};
        tbl[1] = '{dec:1, oct:0, sgn:1, stop:0, adly:1, acdly:0,
            dig:{10{4'd9}}, n:8, sch:5'h03,
            dch:{10{5'h19}}, starts:1};
        tbl[2] = '{dec:0, oct:1, sgn:1, stop:1, adly:0, acdly:2,
            dig:{4'd6,4'd7,4'd0,4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7},
            n:10, sch:5'h03,
            dch:{5'h16,5'h17,5'h10,5'h11,5'h12,
                 5'h13,5'h14,5'h15,5'h16,5'h17},
            starts:0};
        tbl[3] = '{dec:1, oct:1, sgn:0, stop:0, adly:3, acdly:0,
            dig:{4'd9,4'd8,4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1,4'd0},
            n:8, sch:5'h02,
            dch:{5'h19,5'h18,5'h17,5'h16,5'h15,
                 5'h14,5'h13,5'h12,5'h11,5'h10},
            starts:1};
        tbl[4] = '{dec:0, oct:0, sgn:0, stop:0, adly:0, acdly:0,
            dig:{10{4'hF}}, n:10, sch:5'h02,
            dch:{10{5'h17}}, starts:1};

        repeat (3) step();
        chk("rst_active", active, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_order_io", order_io, 0);
        chk("rst_start", start, 0);
        chk("rst_shift", {sh3, sh4}, 0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            clear_mon();
            ack_dly = tbl[i].adly;
            ac_dly = tbl[i].acdly;
            cur_dig = tbl[i].dig;
            start_word(tbl[i].dec, tbl[i].oct, tbl[i].sgn, tbl[i].stop);
            wait_idle($sformatf("v%0d", i));
            check_word($sformatf("v%0d", i), tbl[i].n, tbl[i].sch,
                       tbl[i].dch, tbl[i].starts);
        end

        // Ack held high at start, second order and mode flip mid-word.
        clear_mon();
        ack_dly = 1;
        ac_dly = 0;
        cur_dig = tbl[0].dig;
        dev_hold = 1;
        step();
        start_word(0, 1, 0, 0);
        repeat (4) step();
        chk("hold_valid_low", valid, 0);
        chk("hold_active", active, 1);
        p_dec = 1'b1;
        order = 1'b1;
        step();
        order = 1'b0;
        dev_hold = 0;
        wait_idle("hold");
        check_word("hold", 10, 5'h02, tbl[0].dch, 1);
        repeat (5) step();
        chk("hold_no_restart", active, 0);
        p_dec = 1'b0;

        // Async reset while waiting for the AC on digit 4.
        clear_mon();
        ack_dly = 0;
        ac_dly = 8;
        cur_dig = tbl[0].dig;
        start_word(0, 1, 0, 0);
        for (int c = 0; c < 500 && n_orders < 4; c++) step();
        chk("rst4_reached", n_orders, 4);
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("rst4_valid", valid, 0);
        chk("rst4_active", active, 0);
        chk("rst4_order_io", order_io, 0);
        chk("rst4_start", start, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        clear_mon();
        ac_dly = 1;
        ack_dly = 1;
        start_word(0, 1, 0, 0);
        wait_idle("after_rst");
        check_word("after_rst", 10, 5'h02, tbl[0].dch, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
